// File: rtl/hx711_reader.sv
// rtl/hx711_reader.sv - Avalon-MM HX711 load-cell ADC sequencer
// Waits for DOUT ready, clocks out 25/26/27 SCK pulses and posts the sample with valid/overrun/irq.
module hx711_reader #(
   parameter int CLK_DIV = 50
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        hx711_dout,
   output logic        hx711_sck,
   output logic        irq
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_WAIT_HIGH  = 3'd1;
   localparam logic [2:0] S_WAIT_READY = 3'd2;
   localparam logic [2:0] S_SHIFT_HI   = 3'd3;
   localparam logic [2:0] S_SHIFT_LO   = 3'd4;
   localparam logic [2:0] S_DONE       = 3'd5;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [2:0]  state_q, state_d;
   logic        sck_q, sck_d;
   logic [7:0]  div_q, div_d;
   logic [4:0]  bit_q, bit_d;
   logic [4:0]  npulse_q, npulse_d;
   logic [23:0] shreg_q, shreg_d;
   logic [23:0] data_q, data_d;
   logic        valid_q, valid_d;
   logic        ovr_q, ovr_d;
   logic        en_q, en_d;
   logic [1:0]  gain_q, gain_d;
   logic        irq_en_q, irq_en_d;
   logic [15:0] count_q, count_d;
   logic        sync1_q, sync2_q;

   logic wr_ctrl, wr_stat, rd_data, done;
   logic unused_wdata;

   assign unused_wdata = ^writedata[31:4];
   assign wr_ctrl = chipselect & ~write_n & (address == 2'd2);
   assign wr_stat = chipselect & ~write_n & (address == 2'd1);
   assign rd_data = chipselect &  write_n & (address == 2'd0);
   assign done    = (state_q == S_DONE);

   function automatic logic [4:0] pulses_for(input logic [1:0] g);
      case (g)
         2'd1:    return 5'd26;
         2'd2:    return 5'd27;
         default: return 5'd25;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      sck_d    = sck_q;
      div_d    = div_q;
      bit_d    = bit_q;
      npulse_d = npulse_q;
      shreg_d  = shreg_q;
      data_d   = data_q;
      count_d  = count_q;
      en_d     = wr_ctrl ? writedata[0]   : en_q;
      gain_d   = wr_ctrl ? writedata[2:1] : gain_q;
      irq_en_d = wr_ctrl ? writedata[3]   : irq_en_q;

      case (state_q)
         S_IDLE: begin
            sck_d = 1'b0;
            if (en_d) state_d = S_WAIT_HIGH;
         end
         // A low DOUT left over from the previous conversion must not start a new one.
         S_WAIT_HIGH: begin
            if (sync2_q) state_d = S_WAIT_READY;
         end
         S_WAIT_READY: begin
            if (!sync2_q) begin
               npulse_d = pulses_for(gain_q);
               state_d  = S_SHIFT_HI;
               sck_d    = 1'b1;
               div_d    = 8'd0;
               bit_d    = 5'd0;
            end
         end
         S_SHIFT_HI: begin
            div_d = div_q + 8'd1;
            if (div_q == DIV_LAST) begin
               div_d   = 8'd0;
               sck_d   = 1'b0;
               state_d = S_SHIFT_LO;
               bit_d   = bit_q + 5'd1;
               if (bit_q < 5'd24) shreg_d = {shreg_q[22:0], sync2_q};
            end
         end
         S_SHIFT_LO: begin
            div_d = div_q + 8'd1;
            if (div_q == DIV_LAST) begin
               div_d = 8'd0;
               if (bit_q == npulse_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_SHIFT_HI;
                  sck_d   = 1'b1;
               end
            end
         end
         S_DONE: begin
            data_d  = shreg_q;
            count_d = count_q + 16'd1;
            state_d = S_WAIT_HIGH;
         end
         default: begin
            state_d = S_IDLE;
            sck_d   = 1'b0;
         end
      endcase

      // Disable aborts on the same edge that lands the CONTROL write.
      if (!en_d && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         sck_d   = 1'b0;
      end
   end

   assign valid_d = done ? 1'b1 : (rd_data ? 1'b0 : valid_q);
   assign ovr_d   = (done && valid_q && !rd_data) ? 1'b1 :
                    ((wr_stat && writedata[2]) ? 1'b0 : ovr_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         sck_q    <= 1'b0;
         div_q    <= 8'd0;
         bit_q    <= 5'd0;
         npulse_q <= 5'd0;
         shreg_q  <= 24'd0;
         data_q   <= 24'd0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
         en_q     <= 1'b0;
         gain_q   <= 2'd0;
         irq_en_q <= 1'b0;
         count_q  <= 16'd0;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sck_q    <= sck_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         npulse_q <= npulse_d;
         shreg_q  <= shreg_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
         en_q     <= en_d;
         gain_q   <= gain_d;
         irq_en_q <= irq_en_d;
         count_q  <= count_d;
         sync1_q  <= hx711_dout;
         sync2_q  <= sync1_q;
      end
   end

   always_comb begin
      readdata = 32'd0;
      case (address)
         2'd0:    readdata = {{8{data_q[23]}}, data_q};
         2'd1:    readdata = {29'd0, ovr_q,
                              (state_q == S_SHIFT_HI) || (state_q == S_SHIFT_LO), valid_q};
         2'd2:    readdata = {28'd0, irq_en_q, gain_q, en_q};
         default: readdata = {16'd0, count_q};
      endcase
   end

   assign hx711_sck = sck_q;
   assign irq       = valid_q & irq_en_q;

endmodule

// File: tb/tb_hx711_reader.sv
// tb/tb_hx711_reader.sv - self-checking bench for hx711_reader
// HX711 behavioural model, bus tasks and a scoreboard of expected DATA words.
`timescale 1ns/1ps
module tb_hx711_reader;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic        hx711_dout;
   logic        hx711_sck;
   logic        irq;

   hx711_reader #(.CLK_DIV(D)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .hx711_dout (hx711_dout),
      .hx711_sck  (hx711_sck),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   logic [31:0] exp_q[$];
   logic [15:0] exp_count = 16'd0;

   // HX711 model: bit k of the sample appears after SCK rise k; pulses past 24 release DOUT high.
   logic [23:0] m_sample = 24'd0;
   int          m_base = 0;
   bit          m_ready = 1'b0;
   bit          m_stick = 1'b0;
   int          sck_rises = 0;

   always @(posedge hx711_sck) sck_rises <= sck_rises + 1;

   always_comb begin
      int k;
      k = sck_rises - m_base;
      if (!m_ready)     hx711_dout = 1'b1;
      else if (k == 0)  hx711_dout = 1'b0;
      else if (k <= 24) hx711_dout = m_sample[24 - k];
      else              hx711_dout = !m_stick;
   end

   int   cyc = 0;
   int   run = 0;
   int   bad_hi = 0;
   int   lo_ok = 0;
   int   irq_rise_cyc = -1;
   logic sck_prev = 1'b0;
   logic irq_prev = 1'b0;

   always @(negedge clk) begin
      cyc      <= cyc + 1;
      sck_prev <= hx711_sck;
      irq_prev <= irq;
      if (irq && !irq_prev) irq_rise_cyc <= cyc + 1;
      if (hx711_sck != sck_prev) begin
         run <= 1;
         if (sck_prev) begin
            if (run != D) bad_hi <= bad_hi + 1;
         end else if (run == D) begin
            lo_ok <= lo_ok + 1;
         end
      end else begin
         run <= run + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; write_n = 1'b1; address = a;
      #1 d = readdata;
      @(negedge clk);
      chipselect = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] r;
      bus_read(a, r);
      check_eq(tag, r, exp);
   endtask

   task automatic check_data(input string tag);
      logic [31:0] r, e;
      bus_read(2'd0, r);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
      check_eq(tag, r, e);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic start_conv(input string tag, input logic [23:0] s, input int p, input bit chk_irq);
      int t0, bh0, lo0, w;
      m_sample = s;
      m_base   = sck_rises;
      m_ready  = 1'b1;
      exp_q.push_back({{8{s[23]}}, s});
      bh0 = bad_hi;
      lo0 = lo_ok;
      w   = 0;
      do begin
         @(negedge clk); #1;
         w++;
      end while (!hx711_sck && w < 200);
      check_eq({tag, "_first_rise"}, {31'd0, hx711_sck}, 32'd1);
      t0 = cyc;
      wait_cycles(2 * D * p + 2);
      check_eq({tag, "_pulses"}, 32'(sck_rises - m_base), 32'(p));
      check_eq({tag, "_hi_width_bad"}, 32'(bad_hi - bh0), 32'd0);
      check_eq({tag, "_lo_width_ok"}, 32'(lo_ok - lo0), 32'(p - 1));
      if (chk_irq) check_eq({tag, "_irq_latency"}, 32'(irq_rise_cyc - t0), 32'(2 * D * p + 1));
      exp_count = exp_count + 16'd1;
   endtask

   initial begin
      logic [31:0] r;
      int w, snap;

      #23 check_eq("reset_sck", {31'd0, hx711_sck}, 32'd0);
      check_eq("reset_irq", {31'd0, irq}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      check_reg("reset_data", 2'd0, 32'd0);
      check_reg("reset_status", 2'd1, 32'd0);
      check_reg("reset_control", 2'd2, 32'd0);
      check_reg("reset_count", 2'd3, 32'd0);

      // 1: gain 0, positive full scale
      bus_write(2'd2, 32'h9);
      check_reg("t1_control", 2'd2, 32'h9);
      wait_cycles(5);
      start_conv("t1", 24'h7FFFFF, 25, 1'b1);
      check_reg("t1_status", 2'd1, 32'h1);
      check_data("t1_data");
      check_reg("t1_count", 2'd3, {16'd0, exp_count});

      // 2: gain 2, negative sample, irq behaviour
      bus_write(2'd2, 32'hD);
      wait_cycles(5);
      start_conv("t2", 24'h800001, 27, 1'b1);
      check_eq("t2_irq_high", {31'd0, irq}, 32'd1);
      check_data("t2_data");
      #1 check_eq("t2_irq_dropped", {31'd0, irq}, 32'd0);
      check_reg("t2_count", 2'd3, {16'd0, exp_count});

      // 3: two conversions with no read in between
      bus_write(2'd2, 32'h1);
      wait_cycles(5);
      start_conv("t3a", 24'h123456, 25, 1'b0);
      wait_cycles(5);
      start_conv("t3b", 24'hABCDEF, 25, 1'b0);
      check_reg("t3_status_ovr", 2'd1, 32'h5);
      void'(exp_q.pop_front());
      check_data("t3_data");
      bus_write(2'd1, 32'h4);
      check_reg("t3_status_w1c", 2'd1, 32'h0);
      check_reg("t3_count", 2'd3, {16'd0, exp_count});

      // 4: abort after 10 pulses, then a clean conversion
      m_sample = 24'h5A5A5A;
      m_base   = sck_rises;
      m_ready  = 1'b1;
      w = 0;
      while ((sck_rises - m_base) < 10 && w < 500) begin
         @(negedge clk); #1;
         w++;
      end
      check_eq("t4_reached_10", 32'(sck_rises - m_base), 32'd10);
      bus_write(2'd2, 32'h0);
      #1 check_eq("t4_sck_low", {31'd0, hx711_sck}, 32'd0);
      check_reg("t4_data_kept", 2'd0, 32'hFFABCDEF);
      check_reg("t4_status", 2'd1, 32'h0);
      check_reg("t4_count_kept", 2'd3, {16'd0, exp_count});
      m_ready = 1'b0;
      wait_cycles(5);
      bus_write(2'd2, 32'h1);
      wait_cycles(5);
      start_conv("t4", 24'hFFFFFE, 25, 1'b0);
      check_data("t4_data");

      // 5: DOUT held low after DONE must not start a conversion
      wait_cycles(5);
      m_stick = 1'b1;
      start_conv("t5a", 24'h00F00F, 25, 1'b0);
      check_data("t5a_data");
      snap = sck_rises;
      wait_cycles(100);
      check_eq("t5_no_restart", 32'(sck_rises), 32'(snap));
      check_reg("t5_status_idle", 2'd1, 32'h0);
      m_stick = 1'b0;
      wait_cycles(6);
      start_conv("t5b", 24'h400000, 25, 1'b0);
      check_data("t5b_data");
      check_reg("t5_count", 2'd3, {16'd0, exp_count});

      // 6: COUNT wraps
      @(negedge clk);
      force dut.count_q = 16'hFFFF;
      @(negedge clk);
      release dut.count_q;
      exp_count = 16'hFFFF;
      check_reg("t6_count_preset", 2'd3, 32'h0000FFFF);
      wait_cycles(5);
      start_conv("t6", 24'h000000, 25, 1'b0);
      check_reg("t6_count_wrap", 2'd3, {16'd0, exp_count});
      check_data("t6_data");

      // 7: asynchronous reset mid-conversion
      wait_cycles(5);
      m_sample = 24'h333333;
      m_base   = sck_rises;
      m_ready  = 1'b1;
      w = 0;
      while (!((sck_rises - m_base) >= 3 && hx711_sck) && w < 500) begin
         @(negedge clk); #1;
         w++;
      end
      check_eq("t7_sck_high", {31'd0, hx711_sck}, 32'd1);
      #1 reset_n = 1'b0;
      #1 check_eq("t7_async_sck", {31'd0, hx711_sck}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      m_ready = 1'b0;
      check_reg("t7_control", 2'd2, 32'h0);
      check_reg("t7_count", 2'd3, 32'h0);
      check_reg("t7_data", 2'd0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
